// File: rtl/piso_serializer_if.sv
// -----------------------------------------------------------------------------
// piso_serializer_if
// Parallel-word handshake between an upstream producer and piso_serializer.
//
// Signals:
//   data   [N-1:0]  parallel word, sampled by the serializer only on an accept
//   valid           producer holds a word to send
//   ready           serializer can take a word this cycle
//
// Modports:
//   master  producer side (drives data/valid, observes ready)
//   slave   serializer side (observes data/valid, drives ready)
// -----------------------------------------------------------------------------
interface piso_serializer_if #(
    parameter int N = 8
);
    logic [N-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Parallel-in serial-out transmitter. Takes an N-bit word over a valid/ready
// handshake and shifts it out one bit per clock on serial_o, with frame_o high
// across the frame and done_o marking the final bit. Words accepted during the
// final-bit cycle stream out with no gap.
//
// Parameters:
//   N           word width in bits (N >= 2)
//   MSB_FIRST   1: data[N-1] goes first; 0: data[0] goes first
//   IDLE_LEVEL  serial_o level while no frame is active
//
// Optional feature (compile-time macro PISO_SERIALIZER_PARITY_EN):
//   appends one even-parity bit (XOR of the word) after the data bits in a
//   PARITY state; done_o/ready_o then mark the parity cycle instead.
//
// Ports:
//   clk_i     system clock, rising edge
//   rst_ni    asynchronous active-low reset
//   in_if     slave side of piso_serializer_if (data/valid in, ready out)
//   serial_o  serial data out (registered)
//   frame_o   high while serial_o carries frame bits (registered)
//   done_o    high during the final frame bit (registered)
// -----------------------------------------------------------------------------
module piso_serializer #(
    parameter int N          = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    piso_serializer_if.slave in_if,
    output logic             serial_o,
    output logic             frame_o,
    output logic             done_o
);

    localparam int            CW       = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N);

`ifdef PISO_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;       // bits already shown on serial_o
    logic [N-1:0]  shreg_q, shreg_d;
    logic          serial_q, serial_d;
    logic          frame_q, frame_d;
    logic          done_q, done_d;
`ifdef PISO_SERIALIZER_PARITY_EN
    logic          parity_q, parity_d;
`endif
    logic          final_bit;          // serial_o is showing the last frame bit
    logic          accept;
    logic          at_end;

    // Bit that leaves the word next, and the word with that bit removed.
    function automatic logic head_bit(input logic [N-1:0] w);
        return MSB_FIRST ? w[N-1] : w[0];
    endfunction

    function automatic logic [N-1:0] shift_word(input logic [N-1:0] w);
        return MSB_FIRST ? {w[N-2:0], 1'b0} : {1'b0, w[N-1:1]};
    endfunction

    assign accept = in_if.valid && in_if.ready;

    // ---------------------------------------------------------------- state register
    // NOTE: sequential state uses non-blocking assignments so every flop sees
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            serial_q <= IDLE_LEVEL;
            frame_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            serial_q <= serial_d;
            frame_q  <= frame_d;
            done_q   <= done_d;
`ifdef PISO_SERIALIZER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        serial_d = IDLE_LEVEL;
        frame_d  = 1'b0;
        done_d   = 1'b0;
        at_end   = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            IDLE: begin
                // From idle the word is only loaded; bit 0 shows one edge later.
                if (accept) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shreg_d = in_if.data;
`ifdef PISO_SERIALIZER_PARITY_EN
                    parity_d = ^in_if.data;
`endif
                end
            end
            SHIFT: begin
                if (cnt_q != LAST_CNT) begin
                    serial_d = head_bit(shreg_q);
                    shreg_d  = shift_word(shreg_q);
                    cnt_d    = cnt_q + CW'(1);
                    frame_d  = 1'b1;
`ifndef PISO_SERIALIZER_PARITY_EN
                    done_d   = (cnt_q == LAST_CNT - CW'(1));
`endif
                end else begin
`ifdef PISO_SERIALIZER_PARITY_EN
                    state_d  = PARITY;
                    serial_d = parity_q;
                    frame_d  = 1'b1;
                    done_d   = 1'b1;
`else
                    at_end   = 1'b1;
`endif
                end
            end
`ifdef PISO_SERIALIZER_PARITY_EN
            PARITY: at_end = 1'b1;
`endif
            default: state_d = IDLE;
        endcase

        // Final-bit cycle: either chain the next word or fall back to idle.
        // A chained word puts its first bit out on the accept edge itself so
        // frame_o stays high with no gap; the counter then starts at 1.
        if (at_end) begin
            if (accept) begin
                state_d  = SHIFT;
                serial_d = head_bit(in_if.data);
                shreg_d  = shift_word(in_if.data);
                cnt_d    = CW'(1);
                frame_d  = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
                parity_d = ^in_if.data;
`endif
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
`ifdef PISO_SERIALIZER_PARITY_EN
        final_bit = (state_q == PARITY);
`else
        final_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);
`endif
        in_if.ready = (state_q == IDLE) || final_bit;
    end

    assign serial_o = serial_q;
    assign frame_o  = frame_q;
    assign done_o   = done_q;

endmodule
